// File: rtl/rv32imc_types.sv
// rv32imc_types: shared types for the RV32IMC core slice.
// Holds the multiply/divide FSM states, RV32M funct3 codes
// and helpers deciding which operands are treated as signed.
package rv32imc_types;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIXUP,
        MD_DONE
    } muldiv_state_t;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } muldiv_funct3_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    // MUL is treated as unsigned: its low half is sign-agnostic.
    function automatic logic signed_a(muldiv_funct3_t f);
        return (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV)  || (f == F3_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM only.
    function automatic logic signed_b(muldiv_funct3_t f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the muldiv engine.
// Ports: i_div selects restoring-subtract (1) or shift-add (0);
//   i_acc is the 2*WIDTH accumulator, i_opd the multiplicand or
//   divisor magnitude, o_acc the accumulator after MUL_STEP or
//   DIV_STEP chained single-bit iterations.
module muldiv_step #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opd,
    output logic [2*WIDTH-1:0]   o_acc
);
    import rv32imc_types::*;

    localparam int MAXS = (MUL_STEP > DIV_STEP) ? MUL_STEP : DIV_STEP;

    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;

    always_comb begin
        w_acc   = i_acc;
        w_sum   = '0;
        w_trial = '0;
        for (int i = 0; i < MAXS; i++) begin
            if (i_div && i < DIV_STEP) begin
                // Upper W+1 bits are the remainder shifted left with
                // the next dividend bit already in place.
                w_trial = w_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opd};
                if (!w_trial[WIDTH]) begin
                    w_acc = {w_trial[WIDTH-1:0],
                             w_acc[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc = {w_acc[2*WIDTH-2:0], 1'b0};
                end
            end else if (!i_div && i < MUL_STEP) begin
                // Low half holds the unconsumed multiplier bits;
                // the carry of the add shifts into the top.
                w_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]} +
                        (w_acc[0] ? {1'b0, i_opd} : '0);
                w_acc = {w_sum, w_acc[WIDTH-1:1]};
            end
        end
    end

    assign o_acc = w_acc;

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative RV32M multiply/divide unit, valid/ready.
// Ports: clk, rst (async, active-high); request i_valid/o_ready
//   with i_funct3, i_a, i_b, i_tag; i_flush kills the operation;
//   response o_valid/i_ready with o_result, o_tag; o_busy = !IDLE.
// Optional: define MULDIV_FASTPATH_EN for a one-cycle early-out
//   on trivial operands (results identical in both builds).
// WIDTH must be even and >= 8; MUL_STEP and DIV_STEP (1 or 2)
//   must divide WIDTH.
module iter_muldiv #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);
    import rv32imc_types::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam int DIV_N = WIDTH / DIV_STEP;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t      r_state;
    muldiv_state_t      w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    muldiv_funct3_t     r_f3;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_otag;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_result;

    muldiv_funct3_t     w_f3;
    logic               w_sa;
    logic               w_sb;
    logic               w_accept;
    logic               w_last;
    logic               w_fast;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH-1:0]   w_fix_res;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_step_acc;

    assign w_f3   = muldiv_funct3_t'(i_funct3);
    assign w_sa   = signed_a(w_f3) & i_a[WIDTH-1];
    assign w_sb   = signed_b(w_f3) & i_b[WIDTH-1];
    assign w_amag = w_sa ? -i_a : i_a;
    assign w_bmag = w_sb ? -i_b : i_b;

    assign o_ready  = (r_state == MD_IDLE) & ~i_flush;
    assign w_accept = i_valid & o_ready;
    assign w_last   = (r_cnt == CNT_W'(1));
    assign o_valid  = (r_state == MD_DONE);
    assign o_busy   = (r_state != MD_IDLE);
    assign o_result = r_result;
    assign o_tag    = r_otag;

`ifdef MULDIV_FASTPATH_EN
    logic w_bz;
    logic w_ovf;
    logic w_small;

    // funct3[1] picks remainder over quotient for divides.
    always_comb begin
        w_bz       = (i_b == '0);
        w_ovf      = ~i_funct3[0] & (i_a == MIN_NEG) & (&i_b);
        w_small    = (w_bmag > w_amag);
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (i_funct3[2]) begin
            if (w_bz) begin
                w_fast     = 1'b1;
                w_fast_res = i_funct3[1] ? i_a : '1;
            end else if (w_ovf) begin
                w_fast     = 1'b1;
                w_fast_res = i_funct3[1] ? '0 : MIN_NEG;
            end else if (w_small) begin
                w_fast     = 1'b1;
                w_fast_res = i_funct3[1] ? i_a : '0;
            end
        end else if (i_a == '0 || i_b == '0) begin
            w_fast = 1'b1;
        end
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    muldiv_step #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP),
        .DIV_STEP (DIV_STEP)
    ) u_step (
        .i_div (r_state == MD_DIV),
        .i_acc (r_acc),
        .i_opd (r_opd),
        .o_acc (w_step_acc)
    );

    // Divide by zero keeps the all-ones quotient unsigned, while
    // the remainder negation restores the original dividend.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_q    = (r_neg_q & ~r_bzero) ? -r_acc[WIDTH-1:0]
                                         : r_acc[WIDTH-1:0];
    assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                            : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_res = w_prod[WIDTH-1:0];
        unique case (r_f3)
            F3_MUL:    w_fix_res = w_prod[WIDTH-1:0];
            F3_MULH:   w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            F3_MULHSU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            F3_MULHU:  w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            F3_DIV:    w_fix_res = w_q;
            F3_DIVU:   w_fix_res = w_q;
            F3_REM:    w_fix_res = w_r;
            F3_REMU:   w_fix_res = w_r;
            default:   w_fix_res = w_prod[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    if (w_fast) begin
                        w_next = MD_DONE;
                    end else if (i_funct3[2]) begin
                        w_next = MD_DIV;
                    end else begin
                        w_next = MD_MUL;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                if (i_flush) begin
                    w_next = MD_IDLE;
                end else if (w_last) begin
                    w_next = MD_FIXUP;
                end
            end
            MD_FIXUP: w_next = i_flush ? MD_IDLE : MD_DONE;
            MD_DONE: begin
                if (i_flush || i_ready) begin
                    w_next = MD_IDLE;
                end
            end
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_f3     <= F3_MUL;
            r_tag    <= '0;
            r_otag   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_f3    <= w_f3;
                r_tag   <= i_tag;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_bzero <= (i_b == '0);
                if (i_funct3[2]) begin
                    r_acc <= {{WIDTH{1'b0}}, w_amag};
                    r_opd <= w_bmag;
                    r_cnt <= CNT_W'(DIV_N);
                end else begin
                    r_acc <= {{WIDTH{1'b0}}, w_bmag};
                    r_opd <= w_amag;
                    r_cnt <= CNT_W'(MUL_N);
                end
                if (w_fast) begin
                    r_result <= w_fast_res;
                    r_otag   <= i_tag;
                end
            end
            if (r_state == MD_MUL || r_state == MD_DIV) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == MD_FIXUP && !i_flush) begin
                r_result <= w_fix_res;
                r_otag   <= r_tag;
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: scoreboard bench for iter_muldiv.
// Reference model uses plain 64-bit arithmetic per RV32M rules.
module tb_iter_muldiv;

    localparam int W       = 32;
    localparam int MUL_LAT = W / 2 + 2;
    localparam int DIV_LAT = W / 1 + 2;
    localparam logic [31:0] MINV = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc_edge;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic [4:0]  i_tag = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic        o_busy;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   edges = 0;
    bit   prev_v = 1'b0;
    bit   rdy_rand = 1'b0;
    bit   rdy_val = 1'b1;

    iter_muldiv #(
        .WIDTH    (32),
        .MUL_STEP (2),
        .DIV_STEP (1),
        .TAG_W    (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_tag    (i_tag),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] u;
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        u  = {32'h0, a} * {32'h0, b};
        case (f)
            3'd0: return p[31:0];
            3'd1: return p[63:32];
            3'd2: begin
                p = longint'(sa) * longint'({32'h0, b});
                return p[63:32];
            end
            3'd3: return u[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        bit early;
        early = 1'b0;
`ifdef MULDIV_FASTPATH_EN
        begin
            bit          sgn;
            logic [31:0] ma;
            logic [31:0] mb;
            sgn = (f == 3'd4) || (f == 3'd6);
            ma  = (sgn && a[31]) ? -a : a;
            mb  = (sgn && b[31]) ? -b : b;
            if (f >= 3'd4) begin
                early = (b == 0) || (mb > ma) ||
                        (sgn && a == MINV && b == 32'hFFFF_FFFF);
            end else begin
                early = (a == 0) || (b == 0);
            end
        end
`endif
        if (early) return 1;
        return (f >= 3'd4) ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MINV;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            6: return 32'(0 - $urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] t,
                         input bit push,
                         input logic [31:0] exp_res);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready) begin
            n++;
            if (n > 500) begin
                chk("issue_ready_timeout", 64'(o_ready), 64'h1);
                return;
            end
            @(negedge clk);
        end
        i_valid  = 1'b1;
        i_funct3 = f;
        i_a      = a;
        i_b      = b;
        i_tag    = t;
        if (push) sbq.push_back('{exp_res, t, edges + 1, lat_of(f, a, b)});
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(sbq.size()), 64'h0);
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    // Monitor: latency on first valid cycle, stability while held,
    // result/tag compare on the handshake.
    always @(negedge clk) begin
        if (o_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 64'(o_valid), 64'h0);
            end else begin
                if (!prev_v) begin
                    chk("latency", 64'(edges - sbq[0].acc_edge + 1),
                        64'(sbq[0].lat));
                end
                if (!i_ready) begin
                    chk("hold_result", 64'(o_result), 64'(sbq[0].res));
                    chk("hold_tag", 64'(o_tag), 64'(sbq[0].tag));
                    chk("hold_ready_low", 64'(o_ready), 64'h0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", 64'(o_result), 64'(e.res));
                    chk("tag", 64'(o_tag), 64'(e.tag));
                end
            end
        end
        prev_v = o_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  t;

        #12;
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_result", 64'(o_result), 64'h0);
        chk("rst_tag", 64'(o_tag), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_ready", 64'(o_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd1, MINV, MINV, 5'd1, 1, 32'h4000_0000);
        issue(3'd0, MINV, MINV, 5'd2, 1, 32'h0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 1, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 1, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'hFFFF_FFFF);
        issue(3'd5, 32'h1234, 32'h0, 5'd6, 1, 32'hFFFF_FFFF);
        issue(3'd7, 32'h1234, 32'h0, 5'd7, 1, 32'h1234);
        issue(3'd4, MINV, 32'hFFFF_FFFF, 5'd8, 1, MINV);
        issue(3'd6, MINV, 32'hFFFF_FFFF, 5'd9, 1, 32'h0);
        issue(3'd6, 32'hFFFF_FFF9, 32'h0, 5'd10, 1, 32'hFFFF_FFF9);
        issue(3'd4, 32'd3, 32'hFFFF_FFFB, 5'd11, 1, 32'h0);
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            t = 5'($urandom_range(0, 31));
            issue(f, a, b, t, 1, ref_op(f, a, b));
        end
        drain();
        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        @(posedge clk);

        issue(3'd5, 32'd100, 32'd7, 5'd9, 1, 32'd14);
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 64'(o_valid), 64'h1);
            @(negedge clk);
        end
        rdy_val = 1'b1;
        drain();

        issue(3'd5, 32'hDEAD_BEEF, 32'd13, 5'd12, 0, 32'h0);
        repeat (8) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_busy", 64'(o_busy), 64'h0);
        chk("flush_valid", 64'(o_valid), 64'h0);
        i_flush  = 1'b1;
        i_valid  = 1'b1;
        i_funct3 = 3'd0;
        i_a      = 32'd6;
        i_b      = 32'd7;
        #1;
        chk("flush_idle_ready", 64'(o_ready), 64'h0);
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_idle_not_accepted", 64'(o_busy), 64'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid) n++;
        end
        chk("flush_no_valid", 64'(n), 64'h0);

        issue(3'd0, 32'h1234, 32'h10, 5'd3, 0, 32'h0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'h0);
        chk("async_rst_result", 64'(o_result), 64'h0);
        chk("async_rst_tag", 64'(o_tag), 64'h0);
        chk("async_rst_busy", 64'(o_busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 32'd3, 32'd5, 5'd7, 1, 32'd15);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised iterative RV32M multiply/divide unit for the execute stage.
- Replaces the separate multiplier/divider start-strobe/stall pair with one valid/ready-handshaked engine.
- Configurable operand width, bits retired per cycle for each of MUL and DIV, and a destination tag carried with each operation.
- Supports pipeline flush (kill) of the in-flight operation.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- MUL_STEP, 2, multiplier bits retired per cycle; must divide WIDTH.
- DIV_STEP, 1, quotient bits retired per cycle; must be 1 or 2 and divide WIDTH.
- TAG_W, 5, width of the tag carried with each operation (rd address).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  operation request
- o_ready  out  1  unit can accept a request
- i_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_a  in  WIDTH  rs1 operand
- i_b  in  WIDTH  rs2 operand
- i_tag  in  TAG_W  destination tag
- i_flush  in  1  kill the in-flight operation
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_result  out  WIDTH  result
- o_tag  out  TAG_W  tag of the result
- o_busy  out  1  high in any state except IDLE; used as func_stall source

Behaviour:
- Reset (asynchronous, any state): state=IDLE; o_valid=0, o_result=0, o_tag=0, o_busy=0, o_ready=1; all internal registers cleared.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- o_ready=1 only in IDLE with i_flush=0. A request is accepted when i_valid&o_ready; operands, funct3 and tag are captured that cycle.
- Operand conditioning:
  - Signed operands are converted to magnitudes at accept; result sign is recorded.
  - MULHSU: only rs1 is signed.
  - DIV/REM: the quotient sign is the XOR of the operand signs; the remainder takes the sign of the dividend.
- IDLE -> MUL (funct3[2]=0) or DIV (funct3[2]=1) on accept.
- MUL: shift-add over 2*WIDTH-bit accumulator, MUL_STEP bits per cycle, WIDTH/MUL_STEP cycles, then FIXUP.
- DIV: restoring division, DIV_STEP bits per cycle, WIDTH/DIV_STEP cycles, then FIXUP.
- FIXUP: one cycle.
  - Applies two's-complement negation where required.
  - Selects the low half (MUL) or high half (MULH*) of the product; selects quotient (DIV*) or remainder (REM*).
  - Registers o_result/o_tag. -> DONE.
- DONE: o_valid=1. o_result and o_tag are held stable until i_ready. On i_valid... no; on o_valid&i_ready -> IDLE, o_valid=0 next cycle.
- Latency, accept edge to o_valid: WIDTH/STEP+2 cycles. At default parameters: MUL 18 cycles, DIV 34 cycles.
- Divide by zero (RISC-V semantics):
  - DIVU/DIV quotient = all ones.
  - REMU/REM = dividend.
  - Produced by the normal datapath with sign fixup suppressed.
- Signed overflow (-2^(WIDTH-1) / -1): DIV = -2^(WIDTH-1), REM = 0.
- i_flush, any non-IDLE state: -> IDLE next cycle; o_valid drops next cycle; no result is emitted.
- i_flush in IDLE together with i_valid: flush wins; the request is not accepted.
- i_flush in DONE together with i_ready: the result is dropped. The consumer must ignore it because of the flush.
- Back-to-back operation: a new accept is possible the cycle after the DONE handshake. There is no accept in the DONE cycle itself.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined: early-out path, IDLE -> DONE directly (o_valid one cycle after accept) for these cases:
  - divide by zero;
  - signed overflow;
  - either multiply operand zero (result 0);
  - divisor magnitude > dividend magnitude (quotient 0, remainder = dividend).
- Undefined: every operation takes the full latency. Results are bit-identical in both builds.

Decomposition:
- Add to rv32imc_types:
  - muldiv_state_t enum (IDLE, MUL, DIV, FIXUP, DONE);
  - muldiv_funct3_t enum with the eight encodings above.
- Sub-module muldiv_step: combinational, parametrised by step count. Performs one iteration of either shift-add or restoring subtract, selected by a mode bit, and is instantiated once.

Test Plan:
- MULH a=0x80000000, b=0x80000000 -> o_result=0x40000000 after 18 cycles. MUL, same operands -> 0x00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM, same operands -> 0xFFFFFFFF. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF. REMU, same operands -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM, same operands -> 0. With MULDIV_FASTPATH_EN, each result arrives 1 cycle after accept.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_tag stay stable and o_ready=0; the result is released on i_ready=1.
- Flush asserted at cycle 10 of a DIV -> IDLE next cycle, no o_valid. Then i_flush=1 with i_valid=1 in IDLE -> not accepted.
- Assert rst asynchronously mid-MUL (between clock edges) -> outputs zero immediately. After release, a MUL 3*5 with tag 7 -> o_result=15, o_tag=7.
